// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter that time-shares one external combinational adder
// between NREQ requesters, with operand and result valid/ready handshakes.
module adder_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   resp_valid,
  input  logic [NREQ-1:0]   resp_ready,
  output logic [W:0]        resp_y,
  output logic [W-1:0]      add_a,
  output logic [W-1:0]      add_b,
  input  logic [W:0]        add_y,
  output logic              busy,
  output logic [7:0]        op_count
);

  // state | meaning
  // IDLE  | arbitrate, grant one requester, capture its operands
  // EXEC  | adder inputs stable for one cycle, sum captured at the edge
  // RESP  | result presented to the granted requester until accepted
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam int PW = $clog2(NREQ);

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt;
  logic [PW-1:0] win;
  logic          win_ok;
  int            idx;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    win    = '0;
    win_ok = 1'b0;
    idx    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_valid[idx]) begin
        win    = PW'(idx);
        win_ok = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && win_ok) req_ready[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      gnt        <= '0;
      add_a      <= '0;
      add_b      <= '0;
      resp_y     <= '0;
      resp_valid <= '0;
      busy       <= 1'b0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|(req_valid & req_ready)) begin
            add_a <= req_a[int'(win)*W +: W];
            add_b <= req_b[int'(win)*W +: W];
            gnt   <= win;
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          resp_y     <= add_y;
          resp_valid <= NREQ'(1) << gnt;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready[gnt]) begin
            resp_valid <= '0;
            busy       <= 1'b0;
            op_count   <= op_count + 8'd1;
            ptr        <= (gnt == PW'(NREQ - 1)) ? '0 : gnt + PW'(1);
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Scoreboard bench for adder_rr_arbiter: driver predicts grants and sums from
// a round-robin model, a negedge monitor checks every presented result.
module tb_adder_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [15:0] req_a, req_b;
  logic [4:0]  resp_y, add_y;
  logic [3:0]  add_a, add_b;
  logic        busy;
  logic [7:0]  op_count;

  typedef struct {
    int         w;
    logic [4:0] y;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_ptr = 0;
  int   m_count = 0;

  adder_rr_arbiter #(.NREQ(4), .W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_y(resp_y),
    .add_a(add_a), .add_b(add_b), .add_y(add_y),
    .busy(busy), .op_count(op_count)
  );

  // The shared external adder.
  assign add_y = {1'b0, add_a} + {1'b0, add_b};

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int winner(input logic [3:0] m);
    for (int k = 0; k < 4; k++)
      if (m[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  // Called shortly after a rising edge with the DUT in IDLE; returns likewise.
  task automatic do_op(input logic [3:0] mask, input logic [15:0] av, input logic [15:0] bv,
                       input int stall, input bit keep);
    int w;
    logic [3:0] aw, bw;
    logic [4:0] y;
    req_valid  = mask;
    req_a      = av;
    req_b      = bv;
    resp_ready = 4'b0;
    w  = winner(mask);
    aw = av[w*4 +: 4];
    bw = bv[w*4 +: 4];
    y  = {1'b0, aw} + {1'b0, bw};
    #1;
    chk("req_ready_idle", req_ready, 32'(1) << w);
    chk("busy_idle", busy, 0);
    exp_q.push_back('{w, y});
    @(posedge clk); #1;
    if (!keep) req_valid = 4'b0;
    chk("add_a_exec", add_a, aw);
    chk("add_b_exec", add_b, bw);
    chk("req_ready_exec", req_ready, 0);
    chk("busy_exec", busy, 1);
    @(posedge clk); #1;
    chk("resp_valid_first", resp_valid, 32'(1) << w);
    chk("resp_y_first", resp_y, y);
    for (int s = 0; s < stall; s++) begin
      resp_ready = 4'($urandom) & ~(4'b1 << w);
      if (!keep) req_valid = 4'($urandom) | 4'b0001;
      #1;
      chk("req_ready_resp", req_ready, 0);
      @(posedge clk); #1;
    end
    resp_ready = 4'($urandom) | (4'b1 << w);
    @(posedge clk); #1;
    resp_ready = 4'b0;
    m_ptr   = (w + 1) % 4;
    m_count = (m_count + 1) % 256;
    chk("op_count", op_count, m_count);
    chk("busy_done", busy, 0);
    chk("resp_valid_done", resp_valid, 0);
  endtask

  always @(negedge clk) begin
    chk("req_ready_onehot", ($countones(req_ready) <= 1), 1);
    if (resp_valid != 4'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", resp_valid, 0);
      end else begin
        chk("mon_resp_valid", resp_valid, 32'(1) << exp_q[0].w);
        chk("mon_resp_y", resp_y, exp_q[0].y);
        if (resp_ready[exp_q[0].w]) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = 4'hF;
    req_a      = 16'h1234;
    req_b      = 16'h5678;
    resp_ready = 4'b0;
    #2;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_y", resp_y, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op_count", op_count, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    req_valid = 4'b0;

    // Single request, then maximum operands.
    do_op(4'b0001, 16'h0003, 16'h0004, 0, 0);
    do_op(4'b1000, 16'hF000, 16'hF000, 0, 0);

    // All four valid; granted requester drops out each time.
    for (int k = 0; k < 4; k++)
      do_op(4'hF << k, 16'h3210, 16'h4321, 0, 0);

    // Fairness: req0 and req2 held continuously.
    for (int k = 0; k < 6; k++)
      do_op(4'b0101, 16'h0A05, 16'h0B06, 0, 1);

    // Backpressure on req1 with others requesting during RESP.
    do_op(4'b0010, 16'h0090, 16'h0070, 5, 0);

    // Reset while in EXEC.
    req_valid = 4'b0010;
    req_a     = 16'h00D0;
    req_b     = 16'h00E0;
    @(posedge clk); #1;
    req_valid = 4'b1100;
    req_a     = 16'h5300;
    req_b     = 16'h6400;
    rst_n     = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_resp_valid", resp_valid, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_add_a", add_a, 0);
    chk("mid_rst_resp_y", resp_y, 0);
    chk("mid_rst_op_count", op_count, 0);
    m_ptr   = 0;
    m_count = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(4'b1100, 16'h5300, 16'h6400, 0, 0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      do_op(4'($urandom_range(1, 15)), 16'($urandom), 16'($urandom),
            int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end

    req_valid = 4'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_rr_arbiter.md
# adder_rr_arbiter

Round-robin arbiter and sequencer that shares one 4-bit combinational adder (`a`, `b` → 5-bit `y`) between NREQ requesters. Each requester presents operands with a valid/ready handshake. The block grants one requester at a time and drives the shared adder's operand inputs from registers. It captures the sum and returns it to the granted requester with a second handshake. It sits between the requesting agents and the single adder instance, which stays external and purely combinational.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `W`, default 4: operand width; the sum is W+1 bits.

Ports:
- `clk` in, 1: single clock, all state on the rising edge.
- `rst_n` in, 1: reset, asynchronous and active-low.
- `req_valid` in, NREQ: per-requester operand valid.
- `req_ready` out, NREQ: one-hot accept; at most one bit high.
- `req_a` in, NREQ*W: operand a, requester i at bits [i*W +: W].
- `req_b` in, NREQ*W: operand b, same packing as `req_a`.
- `resp_valid` out, NREQ: one-hot result valid for the granted requester.
- `resp_ready` in, NREQ: per-requester result accept.
- `resp_y` out, W+1: result bus shared by all requesters; qualified by `resp_valid`.
- `add_a` out, W: to shared adder input a (registered).
- `add_b` out, W: to shared adder input b (registered).
- `add_y` in, W+1: from shared adder output y.
- `busy` out, 1: high in EXEC or RESP.
- `op_count` out, 8: completed operations, wraps 255→0.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner = first i with `req_valid[i]`=1, scanning from pointer `ptr` upward, mod NREQ.
  - `req_ready[winner]`=1 combinationally; all other `req_ready` bits 0.
  - If no `req_valid` bit is set: no grant, stay in IDLE.
  - On an edge where `req_valid[w]` & `req_ready[w]`: register `add_a`←`req_a[w]`, `add_b`←`req_b[w]`, `gnt`←w; go to EXEC.
- EXEC: one cycle with the adder inputs stable. At the edge, `resp_y`←`add_y`; go to RESP.
- RESP:
  - `resp_valid[gnt]`=1; `resp_y` held.
  - On an edge with `resp_ready[gnt]`=1: `op_count`++, `ptr`←(gnt+1) mod NREQ, go to IDLE.
  - `resp_ready` bits of other requesters are ignored.
- `req_ready` is 0 in every state other than IDLE, so there is never more than one operation in flight.
- Arithmetic: `add_y` is the full W+1-bit unsigned sum and is captured unmodified; no overflow is possible.
- A requester must hold `req_valid` and its operands stable until accepted. Deasserting before acceptance is legal; that requester is simply not granted.
- `add_a` and `add_b` keep their last operands after the operation completes; they are not cleared.

## Timing
- Reset values (`rst_n`=0, applied immediately and asynchronously):
  - State = IDLE.
  - `req_ready`=0 (forced while `rst_n` is low).
  - `resp_valid`=0, `resp_y`=0.
  - `add_a`=0, `add_b`=0.
  - `busy`=0, `op_count`=0, `ptr`=0.
- Latency:
  - Request accepted at edge E0 → EXEC for the cycle after E0 → `resp_valid` high after E1.
  - Result therefore appears 2 cycles after acceptance.
- Throughput: with `resp_ready` held high, one operation completes every 3 cycles (IDLE, EXEC, RESP).
- `ptr` only updates on response completion. A request that arrives in EXEC or RESP waits for the next IDLE arbitration.
- Simultaneous valids: exactly one is granted, per the round-robin order from `ptr`.
- Reset mid-operation (EXEC or RESP): the in-flight result is discarded, no `resp_valid` is issued, and `op_count` is not incremented.
- After the `rst_n` deassertion edge, the first grant is possible in the first IDLE cycle.

## Test plan
All scenarios use NREQ=4, W=4.
1. Single request: req0 a=3, b=4 → `req_ready[0]` in the same cycle; `add_a`=3, `add_b`=4 in EXEC; `resp_valid[0]`=1 with `resp_y`=7 two cycles after acceptance; `op_count`=1.
2. Max operands: req3 a=15, b=15 → `resp_y`=30 (5'b11110) on `resp_valid[3]`.
3. All four valid out of reset, operands a=i, b=i+1 → grant order 0,1,2,3; `resp_y`=1,3,5,7; `op_count`=4; each operation takes 3 cycles.
4. Fairness: req0 and req2 held valid continuously for 6 operations → grant order 0,2,0,2,0,2; req1 and req3 never granted.
5. Backpressure: `resp_ready[1]` held low for 5 cycles in RESP → `resp_valid[1]` and `resp_y` stay stable; no `req_ready` while req0 is valid; the operation completes on the first cycle `resp_ready[1]`=1.
6. Reset during EXEC: all outputs go to 0 at once, `op_count`=0; after release, a pending req2 is granted first, because `ptr`=0 and req0 and req1 are idle.
